// File: rtl/vram_blit.sv
// Pixel frame buffer with a CPU word port, an always-served video read port and a fill/clear engine.
// Latency: CPU and video reads return one cycle later; the engine writes one pixel (fill) or one word (clear) per cycle.
// Backpressure: o_ready drops while the engine runs; CPU accesses and new starts arriving then are dropped silently.
module vram_blit #(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 128,
    parameter int BPP    = 8,
    localparam int PPW   = 32 / BPP,
    localparam int WORDS = WIDTH * HEIGHT / PPW,
    localparam int AW    = $clog2(WORDS),
    localparam int XW    = $clog2(WIDTH),
    localparam int YW    = $clog2(HEIGHT)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic          i_re,
    input  logic [AW-1:0] i_adr,
    input  logic [31:0]   i_wd,
    output logic [31:0]   o_rd,
    output logic          o_rvalid,
    output logic          o_ready,
    input  logic          i_mev,
    input  logic [AW-1:0] i_adrv,
    output logic [31:0]   o_qv,
    input  logic          i_fill_start,
    input  logic          i_clr,
    input  logic [XW-1:0] i_fill_x,
    input  logic [YW-1:0] i_fill_y,
    input  logic [XW:0]   i_fill_w,
    input  logic [YW:0]   i_fill_h,
    input  logic [BPP-1:0] i_color,
    output logic          o_busy,
    output logic          o_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_CLEAR
    } state_t;

    localparam logic [XW:0]   W_LIM    = (XW+1)'(WIDTH);
    localparam logic [YW:0]   H_LIM    = (YW+1)'(HEIGHT);
    localparam logic [AW-1:0] LAST_ADR = AW'(WORDS - 1);
    localparam int            BYP      = BPP / 8;
    localparam logic [31:0]   PIX_MASK = (32'd1 << BYP) - 32'd1;

    state_t          state_q, state_d;
    logic [XW-1:0]   fx_q, fx_d;
    logic [YW-1:0]   fy_q, fy_d;
    logic [XW:0]     ew_q, ew_d, cx_q, cx_d;
    logic [YW:0]     eh_q, eh_d, cy_q, cy_d;
    logic [BPP-1:0]  color_q, color_d;
    logic [AW-1:0]   clr_adr_q, clr_adr_d;
    logic            done_q, done_d;
    logic [31:0]     rd_q, rd_d;
    logic            rvalid_q, rvalid_d;
    logic [31:0]     qv_q, qv_d;

    // Storage is deliberately left out of reset so contents survive an aborted operation.
    logic [31:0]     mem [WORDS];

    logic [XW:0]     x_room, ew_new;
    logic [YW:0]     y_room, eh_new;
    logic [XW:0]     px;
    logic [YW:0]     py;
    logic [31:0]     pix_lin;
    logic [AW-1:0]   fill_adr;
    logic [1:0]      lane;
    logic [3:0]      lane_be;
    logic            wr_en;
    logic [AW-1:0]   wr_adr;
    logic [3:0]      wr_be;
    logic [31:0]     wr_dat;
    logic [31:0]     vid_word;
    logic            idle;

    assign idle = (state_q == ST_IDLE);

    // Clip the requested rectangle to the screen; a zero extent means nothing to draw.
    always_comb begin
        x_room = ({1'b0, i_fill_x} < W_LIM) ? (W_LIM - {1'b0, i_fill_x}) : '0;
        y_room = ({1'b0, i_fill_y} < H_LIM) ? (H_LIM - {1'b0, i_fill_y}) : '0;
        ew_new = (i_fill_w < x_room) ? i_fill_w : x_room;
        eh_new = (i_fill_h < y_room) ? i_fill_h : y_room;
    end

    // Map the current fill pixel to its word address and the byte lanes it occupies.
    always_comb begin
        px       = {1'b0, fx_q} + cx_q;
        py       = {1'b0, fy_q} + cy_q;
        pix_lin  = 32'(py) * 32'(WIDTH) + 32'(px);
        fill_adr = AW'(pix_lin / 32'(PPW));
        lane     = 2'(pix_lin % 32'(PPW));
        lane_be  = 4'(PIX_MASK << (32'(lane) * 32'(BYP)));
    end

    // Single write port: the CPU owns it in IDLE, the engine owns it otherwise.
    always_comb begin
        wr_en  = 1'b0;
        wr_adr = '0;
        wr_be  = '0;
        wr_dat = {PPW{color_q}};
        case (state_q)
            ST_IDLE: begin
                if (i_we) begin
                    wr_en  = 1'b1;
                    wr_adr = i_adr;
                    wr_be  = i_be;
                    wr_dat = i_wd;
                end
            end
            ST_FILL: begin
                wr_en  = 1'b1;
                wr_adr = fill_adr;
                wr_be  = lane_be;
            end
            ST_CLEAR: begin
                wr_en  = 1'b1;
                wr_adr = clr_adr_q;
                wr_be  = 4'hF;
            end
            default: ;
        endcase
    end

    // Byte-masked memory write.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_adr][8*b +: 8] <= wr_dat[8*b +: 8];
                end
            end
        end
    end

    // Read paths: video forwards a same-cycle write so the display never sees a stale word; CPU reads see pre-write data.
    always_comb begin
        vid_word = mem[i_adrv];
        for (int b = 0; b < 4; b++) begin
            if (wr_en && (wr_adr == i_adrv) && wr_be[b]) begin
                vid_word[8*b +: 8] = wr_dat[8*b +: 8];
            end
        end
        qv_d     = i_mev ? vid_word : qv_q;
        rvalid_d = i_re && idle;
        rd_d     = (i_re && idle) ? mem[i_adr] : rd_q;
    end

    // Engine next-state: start decode in IDLE, row-major pixel walk in FILL, linear word walk in CLEAR.
    always_comb begin
        state_d   = state_q;
        fx_d      = fx_q;
        fy_d      = fy_q;
        ew_d      = ew_q;
        eh_d      = eh_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        color_d   = color_q;
        clr_adr_d = clr_adr_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_clr) begin
                    state_d   = ST_CLEAR;
                    clr_adr_d = '0;
                    color_d   = i_color;
                end else if (i_fill_start) begin
                    fx_d    = i_fill_x;
                    fy_d    = i_fill_y;
                    ew_d    = ew_new;
                    eh_d    = eh_new;
                    color_d = i_color;
                    cx_d    = '0;
                    cy_d    = '0;
                    if ((ew_new == '0) || (eh_new == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (cx_q == ew_q - (XW+1)'(1)) begin
                    cx_d = '0;
                    if (cy_q == eh_q - (YW+1)'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cy_d = cy_q + (YW+1)'(1);
                    end
                end else begin
                    cx_d = cx_q + (XW+1)'(1);
                end
            end
            ST_CLEAR: begin
                if (clr_adr_q == LAST_ADR) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    clr_adr_d = clr_adr_q + AW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and output registers; reset aborts any operation without a done pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            fx_q      <= '0;
            fy_q      <= '0;
            ew_q      <= '0;
            eh_q      <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            color_q   <= '0;
            clr_adr_q <= '0;
            done_q    <= 1'b0;
            rd_q      <= '0;
            rvalid_q  <= 1'b0;
            qv_q      <= '0;
        end else begin
            state_q   <= state_d;
            fx_q      <= fx_d;
            fy_q      <= fy_d;
            ew_q      <= ew_d;
            eh_q      <= eh_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            color_q   <= color_d;
            clr_adr_q <= clr_adr_d;
            done_q    <= done_d;
            rd_q      <= rd_d;
            rvalid_q  <= rvalid_d;
            qv_q      <= qv_d;
        end
    end

    assign o_busy   = !idle;
    assign o_ready  = idle;
    assign o_done   = done_q;
    assign o_rd     = rd_q;
    assign o_rvalid = rvalid_q;
    assign o_qv     = qv_q;

endmodule
